// File: rtl/fifo_pkg.sv
// Shared types for the parametrised synchronous FIFO (fifo_sync_param).
// Optional almost-full/almost-empty flags are enabled by the FIFO_ALMOST_FLAGS_EN macro.
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    WRITE  = 3'b001,
    READ   = 3'b010,
    NO_OP  = 3'b011,
    WR_RD  = 3'b100,
    WR_ERR = 3'b101,
    RD_ERR = 3'b110
  } fifo_state_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
// almost_full/almost_empty exist only when FIFO_ALMOST_FLAGS_EN is defined.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [AW:0]           data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic                  almost_full;
  logic                  almost_empty;
`endif

  modport master (
    output wr_en, rd_en, d_in,
    input  d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
`ifdef FIFO_ALMOST_FLAGS_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  wr_en, rd_en, d_in,
    output d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
`ifdef FIFO_ALMOST_FLAGS_EN
    , output almost_full, almost_empty
`endif
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file with synchronous write and registered read.
// Read and write of the same address on one edge returns the old contents.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          re,
  input  logic [$clog2(DEPTH)-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // storage write; contents need no reset because pointers and count define validity
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with simultaneous read/write and registered status flags.
// Define FIFO_ALMOST_FLAGS_EN to add registered almost_full/almost_empty outputs.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  fifo_sync_param_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [AW:0] AFULL_CNT  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(1);
`endif

  fifo_state_t   state_r;
  fifo_state_t   next_state_s;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          full_r;
  logic          empty_r;
  logic          rd_err_r;
  logic          rd_err_s;
  logic          we_s;
  logic          re_s;
  logic          wr_ack_s;
  logic          wr_err_s;
  logic          rd_ack_s;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full_r;
  logic          almost_empty_r;
`endif

  // request arbitration against the current occupancy
  always_comb begin
    next_state_s = NO_OP;
    if (reset) begin
      next_state_s = INIT;
    end else if (bus.wr_en && bus.rd_en && !empty_r) begin
      next_state_s = WR_RD;
    end else if (bus.wr_en && bus.rd_en) begin
      next_state_s = WRITE;
    end else if (bus.wr_en && !full_r) begin
      next_state_s = WRITE;
    end else if (bus.wr_en) begin
      next_state_s = WR_ERR;
    end else if (bus.rd_en && !empty_r) begin
      next_state_s = READ;
    end else if (bus.rd_en) begin
      next_state_s = RD_ERR;
    end else begin
      next_state_s = NO_OP;
    end
  end

  // storage strobes and next occupancy for the chosen action
  always_comb begin
    we_s     = (next_state_s == WRITE) || (next_state_s == WR_RD);
    re_s     = (next_state_s == READ)  || (next_state_s == WR_RD);
    rd_err_s = !reset && bus.rd_en && empty_r;
    case (next_state_s)
      INIT:    count_next_s = '0;
      WRITE:   count_next_s = count_r + (AW+1)'(1);
      READ:    count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // state, pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= INIT;
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      rd_err_r <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
`endif
    end else begin
      state_r  <= next_state_s;
      if (we_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (re_s) begin
        head_r <= head_r + AW'(1);
      end
      count_r  <= count_next_s;
      full_r   <= (count_next_s == FULL_CNT);
      empty_r  <= (count_next_s == '0);
      rd_err_r <= rd_err_s;
`ifdef FIFO_ALMOST_FLAGS_EN
      almost_full_r  <= (count_next_s >= AFULL_CNT);
      almost_empty_r <= (count_next_s <= AEMPTY_CNT);
`endif
    end
  end

  // ack/err pulses decoded from the registered state of the previous edge
  always_comb begin
    wr_ack_s = 1'b0;
    wr_err_s = 1'b0;
    rd_ack_s = 1'b0;
    case (state_r)
      WRITE:  wr_ack_s = 1'b1;
      READ:   rd_ack_s = 1'b1;
      WR_RD: begin
        wr_ack_s = 1'b1;
        rd_ack_s = 1'b1;
      end
      WR_ERR: wr_err_s = 1'b1;
      default: begin
        wr_ack_s = 1'b0;
        wr_err_s = 1'b0;
        rd_ack_s = 1'b0;
      end
    endcase
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (tail_r),
    .wdata (bus.d_in),
    .re    (re_s),
    .raddr (head_r),
    .rdata (bus.d_out)
  );

  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.data_count = count_r;
  assign bus.wr_ack     = wr_ack_s;
  assign bus.wr_err     = wr_err_s;
  assign bus.rd_ack     = rd_ack_s;
  assign bus.rd_err     = rd_err_r;
`ifdef FIFO_ALMOST_FLAGS_EN
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
`endif

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO: generalised successor of the fixed 8-deep, 3-bit-pointer FIFO.
- Configurable data width and power-of-two depth.
- Adds simultaneous read+write in one cycle and registered status/ack/error flags.
- Sits between producer and consumer blocks on a single clock domain.
- Internally: state register + next-state/address calculation + register-file storage.

Parameters:
- DATA_WIDTH, 32, width of d_in/d_out.
- DEPTH, 8, number of entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- d_in  input  DATA_WIDTH  write data.
- d_out  output  DATA_WIDTH  registered read data.
- full  output  1  data_count == DEPTH.
- empty  output  1  data_count == 0.
- wr_ack  output  1  write accepted last cycle.
- wr_err  output  1  write rejected last cycle.
- rd_ack  output  1  read accepted last cycle.
- rd_err  output  1  read rejected last cycle.
- data_count  output  AW+1  occupancy, 0..DEPTH.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset is synchronous and active-high (reset sampled on rising clk).
  - Reset values: head=0, tail=0, data_count=0, empty=1, full=0, all ack/err=0, d_out=0, state=INIT.
  - Reset has priority over wr_en/rd_en.
  - Mid-operation reset discards all contents; the next cycle behaves as empty.
- States (registered, updated each edge from inputs and current count): INIT, NO_OP, WRITE, READ, WR_RD, WR_ERR, RD_ERR.
- State selection, in priority order:
  - reset -> INIT.
  - wr_en & rd_en & !empty -> WR_RD. Allowed even when full: the read frees a slot.
  - wr_en & rd_en & empty -> WRITE. The read is rejected and rd_err=1.
  - wr_en & !full -> WRITE.
  - wr_en & full -> WR_ERR.
  - rd_en & !empty -> READ.
  - rd_en & empty -> RD_ERR.
  - otherwise -> NO_OP.
- Action on the same edge the state is chosen:
  - WRITE: mem[tail]<=d_in; tail+1; count+1.
  - READ: d_out<=mem[head]; head+1; count-1.
  - WR_RD: both the write and the read are performed; count unchanged. If head==tail (full), d_out gets the old entry, not d_in.
  - WR_ERR / RD_ERR / NO_OP: pointers, count and memory hold; d_out holds.
- Latency:
  - d_out, acks, errs, full, empty and data_count update on the accepting edge and are visible the following cycle.
  - Read latency is 1 cycle.
  - Acks and errs are 1-cycle pulses per request cycle.
- Widths:
  - Pointers are AW bits and wrap modulo DEPTH naturally.
  - data_count is AW+1 bits and never exceeds DEPTH or underflows.
- full and empty are derived from the next count and registered; they are never both 1.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- When defined:
  - Adds outputs almost_full (data_count >= DEPTH-1) and almost_empty (data_count <= 1).
  - Both are registered with the same timing as full/empty.
  - Both reset to almost_full=0, almost_empty=1.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg:
  - State encoding constants: INIT=3'b000, WRITE=3'b001, READ=3'b010, NO_OP=3'b011, WR_RD=3'b100, WR_ERR=3'b101, RD_ERR=3'b110.
  - Typedef fifo_state_t.
- One sub-module, fifo_mem:
  - DEPTH x DATA_WIDTH register file.
  - Synchronous write on we; synchronous registered read on re.
  - Instantiated by fifo_sync_param.
- Next-state and pointer calculation stays inline.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, data_count=0, all ack/err=0, d_out=0.
- Write 8 words 0x11..0x88 at DEPTH=8 -> wr_ack each cycle, full=1, data_count=8; a 9th write gives wr_err=1 with count still 8.
- From full, read 8 times -> d_out 0x11..0x88 in order with 1-cycle latency, rd_ack each cycle, empty=1; a 9th read gives rd_err=1 with d_out holding 0x88.
- From full, simultaneous wr_en+rd_en with d_in=0x99 -> wr_ack=1, rd_ack=1, d_out=0x11, data_count stays 8; a later drain ends with 0x99.
- From empty, simultaneous wr_en+rd_en with d_in=0x5A -> wr_ack=1, rd_err=1, data_count=1; the next read returns 0x5A.
- Write 5 words, assert reset for 1 cycle, then read -> rd_err=1, empty=1, count=0.
  - With FIFO_ALMOST_FLAGS_EN defined: almost_full=1 at count 7; almost_empty=1 at count 1.
